// File: rtl/mt_sched.sv
// mt_sched: shares one MTwister core between NREQ requesters, owning its reset/seed pins and trig timing.
// Optional feature macro: MT_SCHED_STATS_EN adds the stat_count delivered-number counter.
module mt_sched #(
  parameter int          NREQ         = 4,
  parameter logic [31:0] DEFAULT_SEED = 32'd5489,
  parameter int          SETTLE       = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic [31:0]     num_out,
  input  logic            reseed_valid,
  input  logic [31:0]     reseed_seed,
  output logic            reseed_ready,
  output logic            busy,
  output logic            mt_rst,
  output logic [31:0]     mt_seed,
  output logic            mt_trig,
  input  logic [31:0]     mt_num,
  input  logic            mt_ready,
`ifdef MT_SCHED_STATS_EN
  output logic [31:0]     stat_count,
`endif
  output logic [1:0]      dbg_state
);

  // Handshakes: req[i] (and reseed_valid) are held by the source until the
  // matching one-cycle ack[i] (reseed_ready) pulse; data transfers in that cycle.
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(SETTLE + 1);

  localparam logic [1:0] S_SEED = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ARB  = 2'd2;
  localparam logic [1:0] S_COOL = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] settle_cnt;
  logic [31:0]   seed_reg;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] winner;
  logic [IW-1:0] idx_b;
  logic          any_req;
  logic          grant;
  int            idx;

  // Round-robin search from last_grant+1; descending loop so the nearest candidate wins.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = 0;
    idx_b   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx   = (int'(last_grant) + k) % NREQ;
      idx_b = IW'(idx);
      if (req[idx_b]) begin
        any_req = 1'b1;
        winner  = idx_b;
      end
    end
  end

  assign grant        = (state == S_ARB) && !reseed_valid && mt_ready && any_req;
  assign reseed_ready = (state == S_ARB) && reseed_valid;
  assign mt_trig      = grant;
  assign mt_rst       = rst || (state == S_SEED);
  assign mt_seed      = seed_reg;
  assign busy         = (state != S_ARB);
  assign dbg_state    = state;

  // last_grant doubles as the winner register during COOL.
  always_comb begin
    ack = '0;
    for (int i = 0; i < NREQ; i++)
      ack[i] = (state == S_COOL) && (last_grant == IW'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_SEED;
      settle_cnt <= '0;
      seed_reg   <= DEFAULT_SEED;
      last_grant <= IW'(NREQ - 1);
      num_out    <= '0;
    end else begin
      case (state)
        S_SEED: begin
          settle_cnt <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (!mt_ready) begin
            settle_cnt <= '0;
          end else if (settle_cnt == CW'(SETTLE - 1)) begin
            settle_cnt <= '0;
            state      <= S_ARB;
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end
        S_ARB: begin
          if (reseed_valid) begin
            seed_reg <= reseed_seed;
            state    <= S_SEED;
          end else if (!mt_ready) begin
            settle_cnt <= '0;
            state      <= S_WAIT;
          end else if (any_req) begin
            num_out    <= mt_num;
            last_grant <= winner;
            state      <= S_COOL;
          end
        end
        S_COOL: state <= S_ARB;
        default: state <= S_SEED;
      endcase
    end
  end

`ifdef MT_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stat_count <= '0;
    else if (reseed_ready)
      stat_count <= '0;
    else if (state == S_COOL)
      stat_count <= stat_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mt_sched.sv
// tb_mt_sched: behavioural MT19937 core drives mt_num/mt_ready; an independent MT19937
// reference fills an expected queue that a monitor pops on every ack.
module tb_mt_sched;
  localparam int          NREQ   = 4;
  localparam logic [31:0] DSEED  = 32'd5489;
  localparam int          SETTLE = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] ack;
  logic [31:0]     num_out;
  logic            reseed_valid = 1'b0;
  logic [31:0]     reseed_seed = '0;
  logic            reseed_ready;
  logic            busy;
  logic            mt_rst;
  logic [31:0]     mt_seed;
  logic            mt_trig;
  logic [31:0]     mt_num = '0;
  logic            mt_ready = 1'b0;
  logic [31:0]     stat_count;
  logic [1:0]      dbg_state;

  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;

  mt_sched #(.NREQ(NREQ), .DEFAULT_SEED(DSEED), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .num_out(num_out),
    .reseed_valid(reseed_valid), .reseed_seed(reseed_seed), .reseed_ready(reseed_ready),
    .busy(busy), .mt_rst(mt_rst), .mt_seed(mt_seed), .mt_trig(mt_trig),
    .mt_num(mt_num), .mt_ready(mt_ready),
`ifdef MT_SCHED_STATS_EN
    .stat_count(stat_count),
`endif
    .dbg_state(dbg_state)
  );

`ifndef MT_SCHED_STATS_EN
  assign stat_count = '0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- MT19937 generator banks (0: core model, 1: reference) ----------------
  logic [31:0] gen_st [2][624];

  function automatic logic [31:0] temper(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C5680);
    y = y ^ ((y << 15) & 32'hEFC60000);
    y = y ^ (y >> 18);
    return y;
  endfunction

  task automatic gen_init(input int b, input logic [31:0] s);
    gen_st[b][0] = s;
    for (int i = 1; i < 624; i++)
      gen_st[b][i] = 32'(32'd1812433253 * (gen_st[b][i-1] ^ (gen_st[b][i-1] >> 30))) + 32'(i);
  endtask

  task automatic gen_twist(input int b);
    logic [31:0] y;
    for (int i = 0; i < 624; i++) begin
      y = {gen_st[b][i][31], gen_st[b][(i + 1) % 624][30:0]};
      gen_st[b][i] = gen_st[b][(i + 397) % 624] ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'h0);
    end
  endtask

  // ---------------- behavioural MTwister core ----------------
  int          emu_idx = 0;
  int          emu_wait = 0;
  logic        s_rst, s_trig;
  logic [31:0] s_seed;

  initial begin
    forever begin
      @(negedge clk);
      s_rst  = mt_rst;
      s_trig = mt_trig;
      s_seed = mt_seed;
      @(posedge clk);
      #1;
      if (s_rst) begin
        gen_init(0, s_seed);
        gen_twist(0);
        emu_idx  = 0;
        emu_wait = $urandom_range(3, 10);
        mt_ready = 1'b0;
      end else if (emu_wait > 0) begin
        emu_wait--;
        if (emu_wait == 0) mt_ready = 1'b1;
      end else if (s_trig) begin
        emu_idx++;
        if (emu_idx == 624) begin
          mt_ready = 1'b0;
          gen_twist(0);
          emu_idx  = 0;
          emu_wait = $urandom_range(3, 12);
        end
      end
      mt_num = temper(gen_st[0][emu_idx]);
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic ref_fill();
    gen_twist(1);
    for (int i = 0; i < 624; i++) exp_q.push_back(temper(gen_st[1][i]));
  endtask

  task automatic ref_seed(input logic [31:0] s);
    gen_init(1, s);
    exp_q.delete();
    ref_fill();
  endtask

  // ---------------- monitor ----------------
  logic [NREQ-1:0] req_prev = '0;
  logic            trig_prev = 1'b0;
  int              rr_last = NREQ - 1;
  int              seed_run = 0;
  int              ready_run = 0;
  int              model_cnt = 0;
  logic [31:0]     exp_seed = DSEED;

  initial begin
    int w, exp_w, j;
    forever begin
      @(negedge clk);
      ready_run = mt_ready ? ready_run + 1 : 0;
      if (rst) begin
        ref_seed(DSEED);
        exp_seed  = DSEED;
        rr_last   = NREQ - 1;
        model_cnt = 0;
        seed_run  = 0;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_num_out", num_out, 32'd0);
        chk("rst_reseed_ready", 32'(reseed_ready), 32'd0);
        chk("rst_mt_trig", 32'(mt_trig), 32'd0);
        chk("rst_mt_rst", 32'(mt_rst), 32'd1);
        chk("rst_mt_seed", mt_seed, DSEED);
        chk("rst_busy", 32'(busy), 32'd1);
`ifdef MT_SCHED_STATS_EN
        chk("rst_stat_count", stat_count, 32'd0);
`endif
        trig_prev = 1'b0;
      end else begin
        if (mt_rst) begin
          seed_run++;
          chk("seed_value", mt_seed, exp_seed);
        end else if (seed_run > 0) begin
          chk("seed_pulse_len", 32'(seed_run), 32'd1);
          seed_run = 0;
        end
        if (mt_trig) chk("trig_after_settle", 32'(ready_run >= SETTLE + 1), 32'd1);
        chk("ack_follows_trig", 32'(ack != '0), 32'(trig_prev));
`ifdef MT_SCHED_STATS_EN
        chk("stat_count", stat_count, 32'(model_cnt));
`endif
        if (ack != '0) begin
          chk("ack_onehot", 32'($onehot(ack)), 32'd1);
          w = -1;
          for (int i = NREQ - 1; i >= 0; i--) if (ack[i]) w = i;
          exp_w = -1;
          for (int k = 1; k <= NREQ; k++) begin
            j = (rr_last + k) % NREQ;
            if (exp_w < 0 && req_prev[j]) exp_w = j;
          end
          chk("rr_winner", 32'(w), 32'(exp_w));
          rr_last = w;
          if (exp_q.size() == 0) ref_fill();
          chk("num_out", num_out, exp_q.pop_front());
          model_cnt++;
        end
        if (reseed_ready) begin
          ref_seed(reseed_seed);
          exp_seed  = reseed_seed;
          model_cnt = 0;
        end
        trig_prev = mt_trig;
      end
      req_prev = req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic get_one(input int r, output logic [31:0] v);
    bit got;
    got = 0;
    v   = '0;
    @(posedge clk); #1 req[r] = 1'b1;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (ack[r]) begin
        got = 1;
        v   = num_out;
      end
    end
    @(posedge clk); #1 req[r] = 1'b0;
    if (!got) chk("get_one_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [31:0]     v;
    logic [NREQ-1:0] ack_s;
    logic            rr_s;
    int              n, prev, w;
    longint          last_c;
    bit              got, early, saw_gap;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // first two numbers after seed 5489
    get_one(0, v);
    chk("first_num_5489", v, 32'd3499211612);
    get_one(0, v);
    chk("second_num_5489", v, 32'd581869302);

    // all requesters held: strict rotation, one idle cycle between acks
    idle(2);
    req = '1;
    n = 0; prev = 0; last_c = 0;
    for (int c = 0; c < 200 && n < 8; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        w = 0;
        for (int i = NREQ - 1; i >= 0; i--) if (ack[i]) w = i;
        if (n > 0) begin
          chk("rot_order", 32'(w), 32'((prev + 1) % NREQ));
          chk("rot_gap", 32'(cyc - last_c), 32'd2);
        end
        prev = w; last_c = cyc; n++;
      end
    end
    chk("rot_count", 32'(n), 32'd8);
    @(posedge clk); #1 req = '0;

    // reseed and request arrive together: reseed wins
    idle(4);
    reseed_valid = 1'b1; reseed_seed = 32'h1; req[1] = 1'b1;
    got = 0; early = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (ack != '0) early = 1;
      if (reseed_ready) got = 1;
    end
    chk("reseed_before_ack", 32'(got && !early), 32'd1);
    @(posedge clk); #1 reseed_valid = 1'b0;
    @(negedge clk);
    chk("seed_cycle_mt_rst", 32'(mt_rst), 32'd1);
    chk("seed_cycle_mt_seed", mt_seed, 32'h1);
    got = 0; v = '0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (ack[1]) begin got = 1; v = num_out; end
    end
    chk("seed1_first_num", v, 32'd1791095845);
    @(posedge clk); #1 req[1] = 1'b0;

    // drain across the regeneration boundary
    idle(2);
    req[2] = 1'b1;
    n = 0; saw_gap = 0; last_c = cyc;
    for (int c = 0; c < 10000 && n < 700; c++) begin
      @(negedge clk);
      if (ack[2]) begin
        if (n > 0 && cyc - last_c > 2) saw_gap = 1;
        last_c = cyc; n++;
      end
    end
    chk("drain_count", 32'(n), 32'd700);
    chk("drain_regen_pause", 32'(saw_gap), 32'd1);
    @(posedge clk); #1 req[2] = 1'b0;

    // reset asserted in the COOL cycle
    idle(3);
    req[3] = 1'b1;
    got = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (mt_trig) got = 1;
    end
    chk("cool_rst_grant_seen", 32'(got), 32'd1);
    @(posedge clk); #1 rst = 1'b1; req[3] = 1'b0;
    @(negedge clk);
    chk("cool_rst_ack", 32'(ack), 32'd0);
    chk("cool_rst_num_out", num_out, 32'd0);
    idle(2);
    rst = 1'b0;
    get_one(0, v);
    chk("restart_first_num", v, 32'd3499211612);

    // randomized traffic with occasional reseeds and resets
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      ack_s = ack;
      rr_s  = reseed_ready;
      @(posedge clk); #1;
      if (rst) rst = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (ack_s[i]) req[i] = 1'($urandom_range(0, 1));
        else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
      end
      if (reseed_valid) begin
        if (rr_s) reseed_valid = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        reseed_valid = 1'b1;
        reseed_seed  = $urandom;
      end
      if ($urandom_range(0, 799) == 0) rst = 1'b1;
    end
    @(negedge clk);
    @(posedge clk); #1;
    req = '0; reseed_valid = 1'b0; rst = 1'b0;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mt_sched.md
# mt_sched

Sequencing and arbitration controller that shares one MTwister instance between NREQ requesters. It owns the generator's reset/seed pins and performs the initial and on-demand reseeding. It issues `trig` only when the generator's read path has settled, and returns one 32-bit number per grant over a req/ack handshake. It sits between the MTwister core and the consumer blocks (test-pattern, dither, noise sources).

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `DEFAULT_SEED`, 32'd5489: seed applied after reset.
- `SETTLE`, 2: consecutive `mt_ready` cycles required before the first sample after any ready gap (≥2).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NREQ: requester i wants one number; held until `ack[i]`.
- `ack` out NREQ: one-cycle pulse; number valid on `num_out` in the same cycle.
- `num_out` out 32: delivered number; held until the next ack.
- `reseed_valid` in 1: reseed request; held until `reseed_ready`.
- `reseed_seed` in 32: seed value, sampled when `reseed_ready` is high.
- `reseed_ready` out 1: one-cycle accept pulse.
- `busy` out 1: high whenever the FSM is not in ARB.
- `mt_rst` out 1: to MTwister `rst`.
- `mt_seed` out 32: to MTwister `seed`.
- `mt_trig` out 1: to MTwister `trig`.
- `mt_num` in 32: from MTwister `r_num`.
- `mt_ready` in 1: from MTwister `ready`.
- `stat_count` out 32: delivered-number counter. Present only with MT_SCHED_STATS_EN.

## Operation
- FSM states:
  - SEED: `mt_rst`=1 for exactly one cycle with `mt_seed`=seed register. Next state WAIT.
  - WAIT: settle counter counts consecutive `mt_ready`=1 cycles and clears on 0. When it reaches SETTLE, go to ARB.
  - ARB:
    - Priority 1: if `reseed_valid`, pulse `reseed_ready`, load `reseed_seed` into the seed register, go to SEED.
    - Priority 2: else if `mt_ready`=0, clear the settle counter and go to WAIT.
    - Priority 3: else if any `req`, grant the round-robin winner. Combinationally assert `mt_trig`=1, register `mt_num` into `num_out`, register the winner index, go to COOL.
    - Otherwise stay in ARB.
  - COOL: `ack[winner]`=1, `num_out` is valid, `mt_trig`=0. Unconditionally return to ARB. This covers the one-cycle SRAM read latency after the index increment.
- Reset: `rst` forces SEED. The seed register resets to DEFAULT_SEED.
- Round-robin: search starts at last_grant+1, modulo NREQ. last_grant resets to NREQ-1, so requester 0 has first priority. last_grant updates only on a grant.
- Reseed has strict priority over requests. Pending `req` lines wait through SEED/WAIT and are not dropped.
- Requester protocol: `req[i]` must stay high until `ack[i]`. `req` is only sampled in ARB. A requester may re-assert `req` in the cycle after its ack.
- `mt_rst` = `rst` OR (state==SEED). `mt_trig` is high only in ARB with a grant.

## Timing
- Reset values:
  - `ack`=0, `num_out`=0, `reseed_ready`=0, `mt_trig`=0.
  - `mt_rst`=1, `mt_seed`=DEFAULT_SEED, `busy`=1, `stat_count`=0.
- Asserting `rst` mid-grant cancels any pending ack. No partial delivery is made.
- Grant latency: `req` seen in ARB → `ack` on the next cycle. Peak throughput is one number per 2 cycles.
- The MTwister `ready` is registered, so after the final EXTR trig it falls while the FSM is in COOL. The next ARB sees 0 and goes to WAIT. No trig is issued during regeneration.
- Reseed latency: `reseed_ready` → SEED (1 cycle) → WAIT (≥ the MTwister init+gen time + SETTLE) → ARB.
- Simultaneous `reseed_valid` and `req` in ARB: the reseed wins. The req is served after the re-settle.
- `reseed_valid` asserted during COOL/WAIT/SEED: accepted at the next ARB.

## Configuration
- `MT_SCHED_STATS_EN` defined:
  - `stat_count` increments on every ack and wraps at 2^32.
  - It clears on `rst` and on reseed accept.
- `MT_SCHED_STATS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset release, `req`=4'b0001: `mt_rst` high for exactly 1 cycle after `rst` falls. First `ack[0]` carries 3499211612 (MT19937, seed 5489); a second request returns 581869302.
- `req`=4'b1111 held continuously: acks rotate 0,1,2,3,0 with exactly one idle cycle between acks. Each `num_out` matches the reference model's next value.
- Drain 624 numbers with `req[2]` held: no `mt_trig` while `mt_ready`=0. Delivery resumes after SETTLE cycles of ready, with value 625 correct.
- `reseed_valid`=1 with `reseed_seed`=32'h1 in the same cycle as `req[1]`: `reseed_ready` pulses first and `mt_seed`=1 during SEED. The next `ack[1]` carries 1791095845.
- Assert `rst` in the COOL cycle: `ack` stays 0, outputs take their reset values, and the restart sequence repeats from seed 5489.
- With MT_SCHED_STATS_EN: 10 acks give `stat_count`=10, and a reseed returns it to 0.
